// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        FILLING  = 2'd1,
        ARMED    = 2'd2
    } state_e;

    localparam int unsigned DEF_MAX_LEN = 8;
    localparam logic [7:0]  DEF_PATTERN = 8'b0000_1101;
    localparam int unsigned DEF_LEN     = 4;
    localparam bit          DEF_OVERLAP = 1'b1;
    localparam int unsigned DEF_COUNT_W = 8;

    function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_det_param_sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment yields 1.
module sat_counter #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] count
);

    logic [COUNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? COUNT_W'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Serial pattern detector with runtime-loadable pattern, length and overlap mode.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int unsigned        MAX_LEN = DEF_MAX_LEN,
    parameter logic [MAX_LEN-1:0] PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int unsigned        LEN     = DEF_LEN,
    parameter bit                 OVERLAP = DEF_OVERLAP,
    parameter int unsigned        COUNT_W = DEF_COUNT_W,
    localparam int unsigned       LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               A,
    input  logic               din_valid,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               det,
    output logic [COUNT_W-1:0] match_count,
    output logic               cfg_err,
    output logic [1:0]         state
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic               ovl_q, ovl_d;
    logic               det_q, det_d;
    logic               err_q, err_d;

    logic [MAX_LEN:0]   win, patx, mask;
    logic               accept, armed, match, cfg_ok;

    // Window includes the incoming bit so the match is flagged on the edge that samples it.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i <= MAX_LEN; i++) begin
            mask[i] = (i < 32'(len_q));
        end
        win    = {hist_q, A};
        patx   = {1'b0, pat_q};
        armed  = (fill_q >= (len_q - LW'(1)));
        accept = en & din_valid & ~cfg_load & (state_q != DISABLED);
        match  = accept & armed & ((win & mask) == (patx & mask));
        cfg_ok = len_ok(32'(cfg_len), MAX_LEN);
    end

    always_comb begin
        hist_d  = hist_q;
        pat_d   = pat_q;
        len_d   = len_q;
        fill_d  = fill_q;
        ovl_d   = ovl_q;
        det_d   = match;
        err_d   = cfg_load & ~cfg_ok;
        state_d = state_q;

        if (cfg_load) begin
            if (cfg_ok) begin
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                ovl_d  = cfg_overlap;
                hist_d = '0;
                fill_d = '0;
            end
        end else if (accept) begin
            hist_d = {hist_q[MAX_LEN-2:0], A};
            if (match && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q < len_q) begin
                fill_d = fill_q + LW'(1);
            end
        end

        if (!en) begin
            state_d = DISABLED;
        end else if (fill_d >= (len_d - LW'(1))) begin
            state_d = ARMED;
        end else begin
            state_d = FILLING;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILLING;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PATTERN;
            len_q   <= LW'(LEN);
            ovl_q   <= OVERLAP;
            det_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            det_q   <= det_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(
        .COUNT_W (COUNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match),
        .clr   (cnt_clr | (cfg_load & cfg_ok)),
        .count (match_count)
    );

    assign det     = det_q;
    assign cfg_err = err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: expected det values queued per driven cycle.
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       rst, A, din_valid, en, cfg_load, cfg_overlap, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       det, cfg_err;
    logic [7:0] match_count;
    logic [1:0] state;

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_q[$];

    seq_det_param #(
        .MAX_LEN (8),
        .PATTERN (8'b0000_1101),
        .LEN     (4),
        .OVERLAP (1'b1),
        .COUNT_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .A           (A),
        .din_valid   (din_valid),
        .en          (en),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .det         (det),
        .match_count (match_count),
        .cfg_err     (cfg_err),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic a, input logic v, input logic exp_det);
        A         = a;
        din_valid = v;
        exp_q.push_back(exp_det);
        @(posedge clk);
        #1;
        check("det", 32'(det), 32'(exp_q.pop_front()));
    endtask

    // bits[n-1] is driven first
    task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, exp[i]);
        end
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic exp_err);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_load    = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        cfg_load    = 1'b0;
        check("cfg_err", 32'(cfg_err), 32'(exp_err));
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; A = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_det", 32'(det), 32'd0);
        check("rst_count", 32'(match_count), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_state", 32'(state), 32'd1);
        rst = 1'b1;

        // default 1101, overlapping
        stream(16'b1101101, 16'b0001001, 7);
        check("ovl_count", 32'(match_count), 32'd2);

        // non-overlapping
        load(8'b1101, 4'd4, 1'b0, 1'b0);
        check("load_clr_count", 32'(match_count), 32'd0);
        stream(16'b1101101, 16'b0001000, 7);
        check("novl_count", 32'(match_count), 32'd1);

        // rejected loads leave everything intact
        load(8'b1111, 4'd0, 1'b1, 1'b1);
        load(8'b1111, 4'd9, 1'b1, 1'b1);
        check("rej_count", 32'(match_count), 32'd1);
        stream(16'b1101, 16'b0001, 4);
        check("rej_after_count", 32'(match_count), 32'd2);

        // enable gap with valid low
        load(8'b1101, 4'd4, 1'b1, 1'b0);
        stream(16'b110, 16'b000, 3);
        en = 1'b0;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        check("gap_state", 32'(state), 32'd0);
        en = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("resume_state", 32'(state), 32'd2);
        step(1'b1, 1'b1, 1'b1);
        check("gap_count", 32'(match_count), 32'd1);

        // reset during the gap discards history
        stream(16'b110, 16'b000, 3);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        check("mid_rst_count", 32'(match_count), 32'd0);
        check("mid_rst_state", 32'(state), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        stream(16'b1101, 16'b0001, 4);
        check("post_rst_count", 32'(match_count), 32'd1);

        // match coincident with cnt_clr
        stream(16'b10, 16'b00, 2);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        cnt_clr = 1'b0;
        check("clr_match_count", 32'(match_count), 32'd1);

        // cfg_load coincident with completing bit
        stream(16'b10, 16'b00, 2);
        load(8'b1101, 4'd4, 1'b1, 1'b0);
        check("load_bit_count", 32'(match_count), 32'd0);
        check("load_bit_state", 32'(state), 32'd1);
        stream(16'b1101, 16'b0001, 4);

        // len 1, back-to-back matches and saturation
        load(8'b1, 4'd1, 1'b1, 1'b0);
        check("len1_state", 32'(state), 32'd2);
        stream(16'b111, 16'b111, 3);
        check("len1_count", 32'(match_count), 32'd3);
        step(1'b0, 1'b1, 1'b0);
        repeat (260) step(1'b1, 1'b1, 1'b1);
        check("sat_count", 32'(match_count), 32'd255);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        cnt_clr = 1'b0;
        check("sat_clr_count", 32'(match_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
